// File: rtl/vidmem_arbiter.sv
// vidmem_arbiter: two-master Wishbone arbiter for video RAM, m0 (scanout) priority with m1 starvation override
// and a no-ack watchdog that returns a bus error to the granted master.
module vidmem_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic g0, g1, starved, timeout;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign starved = starve_cnt == SW'(STARVE_MAX);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  always_comb begin
    s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    s_stb_o = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    s_we_o = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
    s_adr_o = g1 ? m1_adr_i : m0_adr_i;
    s_dat_o = g1 ? m1_dat_i : m0_dat_i;
    s_sel_o = g1 ? m1_sel_i : m0_sel_i;
    // an ack in the final watchdog cycle still completes the beat
    timeout = s_stb_o & ~s_ack_i & (to_cnt == TW'(TIMEOUT - 1));
    m0_ack_o = g0 & s_ack_i & m0_stb_i;
    m1_ack_o = g1 & s_ack_i & m1_stb_i;
    m0_err_o = g0 & timeout;
    m1_err_o = g1 & timeout;
    grant_o = {g1, g0};
    state_nxt = state == IDLE ? ((m1_cyc_i & (~m0_cyc_i | starved)) ? GNT1 : m0_cyc_i ? GNT0 : IDLE)
                              : (s_cyc_o & ~timeout) ? state : IDLE;
    starve_nxt = (~m1_cyc_i | (state == IDLE & state_nxt == GNT1)) ? '0
               : (~g1 & ~starved) ? starve_cnt + SW'(1) : starve_cnt;
    to_nxt = (s_stb_o & ~s_ack_i & ~timeout) ? to_cnt + TW'(1) : '0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      starve_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      starve_cnt <= starve_nxt;
      to_cnt <= to_nxt;
    end
  end
endmodule
